// File: rtl/cube_frame_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : cube_frame_buffer_if
// Description : Write-stream and display-read bus of the cube frame buffer.
//               master : upstream writer / display reader (drives wr_valid,
//                        wr_data, wr_sof, rd_addr)
//               slave  : the frame buffer (drives wr_ready, rd_data)
// Revision    : 1.0 - initial release
// ============================================================================
interface cube_frame_buffer_if;
    logic       wr_valid;   // upstream byte present on wr_data
    logic [7:0] wr_data;    // one latch row of one layer
    logic       wr_sof;     // wr_data is byte 0 of a frame
    logic       wr_ready;   // buffer accepts wr_data this cycle
    logic [5:0] rd_addr;    // {layer[2:0], latch[2:0]}
    logic [7:0] rd_data;    // front-buffer byte at rd_addr

    modport master (
        output wr_valid, wr_data, wr_sof, rd_addr,
        input  wr_ready, rd_data
    );

    modport slave (
        input  wr_valid, wr_data, wr_sof, rd_addr,
        output wr_ready, rd_data
    );
endinterface
`default_nettype wire

// File: rtl/cube_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : cube_frame_buffer
// Description : Double-buffered 8x8x8 LED cube frame store (64 bytes/frame).
//               Upstream fills the back bank byte by byte; the display reads
//               the front bank combinationally. A completed frame waits in
//               the back bank until the display signals frame_end, then the
//               banks swap.
// Ports       : clk            rising-edge system clock
//               rst_n          synchronous active-low reset
//               bus            cube_frame_buffer_if.slave (write stream and
//                              display read port)
//               frame_end      display finished a full layer sweep (pulse)
//               frame_pending  back frame complete, waiting for a swap
//               err_sof        sticky: start-of-frame seen mid-frame
//               swap_count     swaps since reset (only with
//                              CUBE_FB_SWAP_COUNT_EN defined)
// Options     : CUBE_FB_SWAP_COUNT_EN adds the swap_count output.
// Revision    : 1.0 - initial release
// ============================================================================
module cube_frame_buffer (
    input  logic                        clk,
    input  logic                        rst_n,
    cube_frame_buffer_if.slave          bus,
    input  logic                        frame_end,
    output logic                        frame_pending,
    output logic                        err_sof
`ifdef CUBE_FB_SWAP_COUNT_EN
    ,
    output logic [15:0]                 swap_count
`endif
);

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] wptr_q, wptr_d;
    logic       sel_q, sel_d;               // 0: bank0 is front, 1: bank1 is front
    logic       front_valid_q, front_valid_d;
    logic       err_sof_q, err_sof_d;

    logic [7:0] bank0_q [64];
    logic [7:0] bank1_q [64];

    logic       accept;
    logic       swap;
    logic [5:0] wr_addr;

    // ------------------------------------------------------------------
    // Next-state / control
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        wptr_d        = wptr_q;
        sel_d         = sel_q;
        front_valid_d = front_valid_q;
        err_sof_d     = err_sof_q;
        swap          = 1'b0;
        accept        = bus.wr_valid && (state_q == ST_FILL);
        // A start-of-frame byte always lands at address 0.
        wr_addr       = bus.wr_sof ? 6'd0 : wptr_q;

        case (state_q)
            ST_FILL: begin
                // frame_end is deliberately ignored here: a swap only ever
                // follows a frame that was already complete beforehand.
                if (accept) begin
                    if (bus.wr_sof) begin
                        wptr_d = 6'd1;
                        if (wptr_q != 6'd0) begin
                            err_sof_d = 1'b1;
                        end
                    end else begin
                        wptr_d = wptr_q + 6'd1;   // wraps 63 -> 0
                        if (wptr_q == 6'd63) begin
                            state_d = ST_PEND;
                        end
                    end
                end
            end
            ST_PEND: begin
                if (frame_end) begin
                    swap          = 1'b1;
                    sel_d         = ~sel_q;
                    front_valid_d = 1'b1;
                    state_d       = ST_FILL;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_FILL;
            wptr_q        <= 6'd0;
            sel_q         <= 1'b0;
            front_valid_q <= 1'b0;
            err_sof_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            wptr_q        <= wptr_d;
            sel_q         <= sel_d;
            front_valid_q <= front_valid_d;
            err_sof_q     <= err_sof_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame storage: the back bank is the one not selected as front.
    // Contents are not reset; a write in the reset cycle is dropped since
    // that frame is being discarded anyway.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            if (sel_q) begin
                bank0_q[wr_addr] <= bus.wr_data;
            end else begin
                bank1_q[wr_addr] <= bus.wr_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.wr_ready   = (state_q == ST_FILL);
    assign frame_pending  = (state_q == ST_PEND);
    assign err_sof        = err_sof_q;

    // Nothing is shown until the first frame has been swapped in.
    assign bus.rd_data = !front_valid_q ? 8'h00
                       : (sel_q ? bank1_q[bus.rd_addr] : bank0_q[bus.rd_addr]);

`ifdef CUBE_FB_SWAP_COUNT_EN
    logic [15:0] swap_count_q, swap_count_d;

    always_comb begin
        swap_count_d = swap_count_q;
        if (swap) begin
            swap_count_d = swap_count_q + 16'd1;   // wraps FFFF -> 0
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            swap_count_q <= 16'd0;
        end else begin
            swap_count_q <= swap_count_d;
        end
    end

    assign swap_count = swap_count_q;
`else
    logic unused_swap;
    assign unused_swap = swap;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cube_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cube_frame_buffer
// Description : Self-checking bench for cube_frame_buffer. A frame-level
//               model (completed frame array, displayed frame array, byte
//               count, pending flag) is compared against the DUT on every
//               falling edge; directed steps add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cube_frame_buffer;

    logic clk = 1'b0;
    logic rst_n;
    logic frame_end;
    logic frame_pending;
    logic err_sof;
`ifdef CUBE_FB_SWAP_COUNT_EN
    logic [15:0] swap_count;
`endif

    cube_frame_buffer_if bus ();

    cube_frame_buffer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .frame_end     (frame_end),
        .frame_pending (frame_pending),
        .err_sof       (err_sof)
`ifdef CUBE_FB_SWAP_COUNT_EN
        ,
        .swap_count    (swap_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Frame-level model
    // ------------------------------------------------------------------
    logic [7:0] m_frame [64];   // frame being assembled upstream
    logic [7:0] m_front [64];   // frame currently displayed
    int         m_count   = 0;  // bytes placed in the current frame
    bit         m_pending = 1'b0;
    bit         m_shown   = 1'b0;
    bit         m_err     = 1'b0;
    int         m_swaps   = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_count   = 0;
            m_pending = 1'b0;
            m_shown   = 1'b0;
            m_err     = 1'b0;
            m_swaps   = 0;
        end else if (m_pending) begin
            if (frame_end) begin
                m_front   = m_frame;
                m_shown   = 1'b1;
                m_pending = 1'b0;
                m_swaps   = (m_swaps + 1) % 65536;
            end
        end else if (bus.wr_valid) begin
            if (bus.wr_sof) begin
                if (m_count != 0) m_err = 1'b1;
                m_frame[0] = bus.wr_data;
                m_count    = 1;
            end else begin
                m_frame[m_count] = bus.wr_data;
                m_count++;
                if (m_count == 64) begin
                    m_pending = 1'b1;
                    m_count   = 0;
                end
            end
        end
    end

    // Compare process: outputs are stable mid-cycle.
    always @(negedge clk) begin
        if (check_en) begin
            check("cyc_wr_ready", {15'd0, bus.wr_ready}, {15'd0, !m_pending});
            check("cyc_frame_pending", {15'd0, frame_pending}, {15'd0, m_pending});
            check("cyc_err_sof", {15'd0, err_sof}, {15'd0, m_err});
            check("cyc_rd_data", {8'd0, bus.rd_data},
                  {8'd0, (m_shown ? m_front[bus.rd_addr] : 8'h00)});
`ifdef CUBE_FB_SWAP_COUNT_EN
            check("cyc_swap_count", swap_count, m_swaps[15:0]);
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic sof);
        logic rdy;
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        bus.wr_sof   = sof;
        for (int k = 0; k < 200; k++) begin
            #3;
            rdy = bus.wr_ready;
            tick();
            if (rdy) begin
                bus.wr_valid = 1'b0;
                bus.wr_sof   = 1'b0;
                return;
            end
        end
        bus.wr_valid = 1'b0;
        bus.wr_sof   = 1'b0;
        n_checks++;
        n_errors++;
        $display("FAIL send_timeout: byte %h never accepted", d);
    endtask

    task automatic pulse_frame_end();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
    endtask

    task automatic lit_rd(input string name, input logic [5:0] a, input logic [7:0] exp);
        bus.rd_addr = a;
        #1;
        check(name, {8'd0, bus.rd_data}, {8'd0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        frame_end    = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = 8'h00;
        bus.wr_sof   = 1'b0;
        bus.rd_addr  = 6'd0;
        tick();
        tick();
        rst_n    = 1'b1;
        check_en = 1'b1;

        // Reset state: blank front, ready, nothing pending.
        #1;
        check("rst_wr_ready", {15'd0, bus.wr_ready}, 16'd1);
        check("rst_frame_pending", {15'd0, frame_pending}, 16'd0);
        check("rst_err_sof", {15'd0, err_sof}, 16'd0);
        for (int a = 0; a < 64; a++) begin
            lit_rd("rst_sweep", a[5:0], 8'h00);
            tick();
        end

        // Frame 1: 00..3F, no frame_end.
        for (int i = 0; i < 64; i++) send_byte(i[7:0], (i == 0));
        #1;
        check("f1_pending", {15'd0, frame_pending}, 16'd1);
        check("f1_ready", {15'd0, bus.wr_ready}, 16'd0);
        lit_rd("f1_blank", 6'd5, 8'h00);
        tick();
        pulse_frame_end();
        check("f1_ready_after_swap", {15'd0, bus.wr_ready}, 16'd1);
        lit_rd("f1_addr5", 6'd5, 8'h05);
        lit_rd("f1_addr63", 6'd63, 8'h3F);

        // Frame 2: 80..BF, frame_end coincides with the last byte.
        for (int i = 0; i < 63; i++) send_byte(8'h80 + i[7:0], (i == 0));
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'hBF;
        frame_end    = 1'b1;
        tick();
        bus.wr_valid = 1'b0;
        frame_end    = 1'b0;
        #1;
        check("f2_pending", {15'd0, frame_pending}, 16'd1);
        lit_rd("f2_no_swap", 6'd5, 8'h05);
        tick();
        tick();
        pulse_frame_end();
        lit_rd("f2_addr5", 6'd5, 8'h85);
        lit_rd("f2_addr63", 6'd63, 8'hBF);

        // Frame 3: 10 bytes, then a stray start-of-frame.
        for (int i = 0; i < 10; i++) send_byte(8'h10 + i[7:0], (i == 0));
        check("f3_no_err_yet", {15'd0, err_sof}, 16'd0);
        send_byte(8'hAA, 1'b1);
        #1;
        check("f3_err_sof", {15'd0, err_sof}, 16'd1);
        lit_rd("f3_front_kept", 6'd0, 8'h80);
        for (int i = 0; i < 63; i++) send_byte(8'hC0 + i[7:0], 1'b0);
        // A byte offered while pending must be held, not dropped.
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h55;
        bus.wr_sof   = 1'b1;
        tick();
        tick();
        tick();
        check("f3_held_ready", {15'd0, bus.wr_ready}, 16'd0);
        check("f3_held_pending", {15'd0, frame_pending}, 16'd1);
        pulse_frame_end();
        tick();                 // held byte accepted as byte 0 of frame 4
        bus.wr_valid = 1'b0;
        bus.wr_sof   = 1'b0;
        lit_rd("f3_addr0", 6'd0, 8'hAA);
        lit_rd("f3_addr1", 6'd1, 8'hC0);
        lit_rd("f3_addr63", 6'd63, 8'hFE);
        check("f3_err_sticky", {15'd0, err_sof}, 16'd1);

        // Frame 4: complete it, then reset while pending.
        for (int i = 1; i < 64; i++) send_byte(8'h20 + i[7:0], 1'b0);
        #1;
        check("f4_pending", {15'd0, frame_pending}, 16'd1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("r2_wr_ready", {15'd0, bus.wr_ready}, 16'd1);
        check("r2_frame_pending", {15'd0, frame_pending}, 16'd0);
        check("r2_err_sof", {15'd0, err_sof}, 16'd0);
        lit_rd("r2_blank", 6'd5, 8'h00);
        pulse_frame_end();
        check("r2_no_swap_pending", {15'd0, frame_pending}, 16'd0);
        lit_rd("r2_no_swap_blank", 6'd0, 8'h00);
`ifdef CUBE_FB_SWAP_COUNT_EN
        check("r2_swap_count", swap_count, 16'd0);
`endif
        tick();
        tick();
        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cube_frame_buffer.md
CUBE_FRAME_BUFFER -- requirements
Module: cube_frame_buffer

Interface
REQ-001 The block SHALL use reset rst_n (synchronous, active-low) and clock clk; there are no parameters and the geometry is fixed at 8 layers x 8 latches x 8 bits, which is 64 bytes per frame.
REQ-002 clk  input  1  rising-edge system clock (50 MHz).
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 wr_valid  input  1  upstream byte present on wr_data.
REQ-005 wr_data  input  8  frame byte; one latch row of one layer.
REQ-006 wr_sof  input  1  qualifies wr_data as byte 0 of a frame (start-of-frame).
REQ-007 wr_ready  output  1  block accepts wr_data this cycle.
REQ-008 rd_addr  input  6  display read address {layer_i[2:0], latch_i[2:0]}.
REQ-009 rd_data  output  8  front-buffer byte at rd_addr.
REQ-010 frame_end  input  1  one-cycle pulse from the display controller when a full layer sweep completes.
REQ-011 frame_pending  output  1  back buffer is full and waiting for a swap.
REQ-012 err_sof  output  1  sticky flag: wr_sof was accepted while the write pointer was non-zero.

Function
REQ-013 Storage SHALL be two 64x8 banks: the front bank is read by the display and the back bank is written by upstream; bank select sel chooses the front bank.
REQ-014 rd_data SHALL be combinational: rd_data = front[rd_addr], with zero cycles of latency.
REQ-015 rd_data SHALL be 8'h00 while front_valid = 0, where front_valid is cleared by reset and set on the first swap.
REQ-016 FSM states: FILL and PEND; wr_ready = 1 in FILL and 0 in PEND; frame_pending = 1 only in PEND.
REQ-017 In FILL, a byte is accepted when wr_valid && wr_ready; it is written to back[wptr] and wptr increments, modulo 64.
REQ-018 If wr_sof is high on an accepted byte, the byte SHALL be written to address 0 and wptr set to 1.
REQ-019 Under the REQ-018 condition, if wptr != 0 before that byte, err_sof SHALL set and stay set until reset.
REQ-020 wr_sof SHALL be ignored when the byte is not accepted.
REQ-021 Acceptance of the byte at address 63 SHALL move FILL -> PEND on the next edge, with wptr wrapping to 0.
REQ-022 In PEND, frame_end SHALL toggle sel, set front_valid and return to FILL; wr_ready is high the following cycle.
REQ-023 A frame_end in FILL SHALL be ignored, including in the cycle the byte at address 63 is accepted; the swap waits for the next frame_end.
REQ-024 A swap SHALL never occur mid-sweep, because frame_end is the only swap trigger.
REQ-025 Bytes presented in PEND SHALL be held off by wr_ready = 0 and never dropped or overwritten.

Reset
REQ-026 Reset SHALL set: state = FILL, wptr = 0, sel = 0, front_valid = 0, err_sof = 0, wr_ready = 1, frame_pending = 0, rd_data = 8'h00.
REQ-027 Memory contents SHALL not be reset; a frame being written when reset occurs is discarded.
REQ-028 Reset in PEND SHALL discard the pending frame; no swap occurs.

Configuration
REQ-029 Macro CUBE_FB_SWAP_COUNT_EN, when defined, SHALL add an output swap_count [15:0] that is 0 at reset and increments on every swap, wrapping 16'hFFFF -> 0.
REQ-030 When CUBE_FB_SWAP_COUNT_EN is undefined, the swap_count port and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-031 Reset, then sweep rd_addr 0..63 -> rd_data = 8'h00 for every address; wr_ready = 1; frame_pending = 0.
REQ-032 Write 64 bytes 8'h00..8'h3F (wr_sof on the first) with no frame_end -> frame_pending = 1 and wr_ready = 0 one cycle after the 64th byte; rd_data is still 8'h00.
REQ-033 Continue from REQ-032 and pulse frame_end -> next cycle rd_addr = 6'd5 gives rd_data = 8'h05, rd_addr = 6'd63 gives 8'h3F, and wr_ready = 1.
REQ-034 Accept the 64th byte and pulse frame_end in the same cycle -> no swap; frame_pending = 1; the swap happens on the next frame_end.
REQ-035 Write 10 bytes, then a byte 8'hAA with wr_sof -> err_sof = 1, back[0] = 8'hAA, wptr = 1; a further 63 bytes complete the frame.
REQ-036 Assert reset while in PEND -> all REQ-026 values hold and frame_end produces no swap (swap_count = 0 when CUBE_FB_SWAP_COUNT_EN is defined).
